// File: rtl/apb_reg_bank.sv
// apb_reg_bank: APB slave exposing NUM word registers of DW bits.
// A two-state FSM (IDLE/ACCESS) inserts WAIT_CYCLES wait states per transfer.
// Illegal addresses (index >= NUM or unaligned) complete with PSLVERR and
// never modify state.
// Optional feature: define APB_REG_BANK_PSTRB_EN to add the PSTRB port and
// byte-lane write masking. When it is undefined, every write updates the full word.
module apb_reg_bank #(
  parameter int             DW          = 32,
  parameter int             AW          = 16,
  parameter int             NUM         = 8,
  parameter int             WAIT_CYCLES = 0,
  parameter logic [DW-1:0]  RESET_VAL   = '0
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [AW-1:0]     PADDR,
  input  logic [DW-1:0]     PWDATA,
`ifdef APB_REG_BANK_PSTRB_EN
  input  logic [DW/8-1:0]   PSTRB,
`endif
  output logic [DW-1:0]     PRDATA,
  output logic              PREADY,
  output logic              PSLVERR
);

  localparam int IW = AW - 2;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t        state;
  logic [3:0]    wait_cnt;
  logic [DW-1:0] regs [NUM];
  logic [IW-1:0] idx;
  logic          legal;
  logic          complete;
  logic [DW-1:0] rd_word;
  logic [DW-1:0] wmask;

  // The index is widened by one bit so that NUM == 2^IW still compares correctly.
  assign idx      = PADDR[AW-1:2];
  assign legal    = (PADDR[1:0] == 2'b00) && ({1'b0, idx} < (IW+1)'(NUM));
  assign PREADY   = (state == ACCESS) && (wait_cnt == 4'd0);
  assign complete = PSEL && PENABLE && PREADY;
  assign PSLVERR  = PREADY && !legal;
  assign PRDATA   = (PREADY && !PWRITE && legal) ? rd_word : '0;

  // Transfer sequencing: load wait states on setup, count down, then complete or abort.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (PSEL && !PENABLE) begin
            state    <= ACCESS;
            wait_cnt <= 4'(WAIT_CYCLES);
          end
        end
        ACCESS: begin
          if (!PSEL) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
          end else if (PENABLE) begin
            if (wait_cnt != 4'd0) begin
              wait_cnt <= wait_cnt - 4'd1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state    <= IDLE;
          wait_cnt <= 4'd0;
        end
      endcase
    end
  end

  // Byte-lane mask applied to writes. It is all ones unless strobes are enabled.
  always_comb begin
    wmask = '1;
`ifdef APB_REG_BANK_PSTRB_EN
    for (int b = 0; b < DW/8; b++) begin
      wmask[b*8 +: 8] = {8{PSTRB[b]}};
    end
`endif
  end

  // Register storage: commit a legal write on the completing edge only.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < NUM; i++) begin
        regs[i] <= RESET_VAL;
      end
    end else if (complete && PWRITE && legal) begin
      for (int i = 0; i < NUM; i++) begin
        if (idx == IW'(i)) begin
          regs[i] <= (regs[i] & ~wmask) | (PWDATA & wmask);
        end
      end
    end
  end

  // Read mux selects the addressed register. Out-of-range indices return zero.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM; i++) begin
      if (idx == IW'(i)) begin
        rd_word = regs[i];
      end
    end
  end

endmodule

// File: tb/tb_apb_reg_bank.sv
// tb_apb_reg_bank: drives three apb_reg_bank instances (WAIT_CYCLES 0, 3, 2)
// over a shared bus with one PSEL per instance. A transfer-level model predicts
// PREADY/PSLVERR/PRDATA every cycle, and directed vectors pin literal results.
module tb_apb_reg_bank;

  localparam logic [31:0] RV = 32'hA5A5_0F0F;

  logic        PCLK;
  logic        PRESETn;
  logic [2:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [15:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata  [3];
  logic        pready  [3];
  logic        pslverr [3];

  int checks = 0;
  int errors = 0;

  int wcfg [3] = '{0, 3, 2};

  // Model state: whether an instance is in its access phase, the number of
  // access cycles it has already waited, and the register contents.
  bit          acc  [3];
  int          seen [3];
  logic [31:0] mem  [3][8];

  // Three instances, one per wait-state setting.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    apb_reg_bank #(
      .DW(32), .AW(16), .NUM(8),
      .WAIT_CYCLES((g == 0) ? 0 : (g == 1) ? 3 : 2),
      .RESET_VAL(RV)
    ) u_dut (
      .PCLK    (PCLK),
      .PRESETn (PRESETn),
      .PSEL    (psel[g]),
      .PENABLE (penable),
      .PWRITE  (pwrite),
      .PADDR   (paddr),
      .PWDATA  (pwdata),
`ifdef APB_REG_BANK_PSTRB_EN
      .PSTRB   (pstrb),
`endif
      .PRDATA  (prdata[g]),
      .PREADY  (pready[g]),
      .PSLVERR (pslverr[g])
    );
  end

  // Free-running clock with a 10 ns period.
  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  function automatic bit legal(input logic [15:0] a);
    return (a[1:0] == 2'b00) && (a[15:2] < 14'd8);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: applies the transfer rules at each rising edge.
  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int k = 0; k < 3; k++) begin
        acc[k]  <= 1'b0;
        seen[k] <= 0;
        for (int i = 0; i < 8; i++) mem[k][i] <= RV;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (!acc[k]) begin
          if (psel[k] && !penable) begin
            acc[k]  <= 1'b1;
            seen[k] <= 0;
          end
        end else if (!psel[k]) begin
          acc[k] <= 1'b0;
        end else if (penable) begin
          if (seen[k] >= wcfg[k]) begin
            acc[k] <= 1'b0;
            if (pwrite && legal(paddr)) begin
              logic [31:0] nv;
              nv = mem[k][paddr[4:2]];
              for (int b = 0; b < 4; b++) begin
`ifdef APB_REG_BANK_PSTRB_EN
                if (pstrb[b]) nv[b*8 +: 8] = pwdata[b*8 +: 8];
`else
                nv[b*8 +: 8] = pwdata[b*8 +: 8];
`endif
              end
              mem[k][paddr[4:2]] <= nv;
            end
          end else begin
            seen[k] <= seen[k] + 1;
          end
        end
      end
    end
  end

  // Compare every instance's outputs against the model on each falling edge.
  always @(negedge PCLK) begin
    for (int k = 0; k < 3; k++) begin
      bit          er;
      bit          ee;
      logic [31:0] ed;
      er = acc[k] && (seen[k] >= wcfg[k]);
      ee = er && !legal(paddr);
      ed = (er && !pwrite && legal(paddr)) ? mem[k][paddr[4:2]] : 32'h0;
      checkOutput($sformatf("u%0d_pready", k), {31'b0, pready[k]}, {31'b0, er});
      checkOutput($sformatf("u%0d_pslverr", k), {31'b0, pslverr[k]}, {31'b0, ee});
      checkOutput($sformatf("u%0d_prdata", k), prdata[k], ed);
    end
  end

  // One full transfer to instance k, starting 1 ns after a rising edge.
  // It returns 1 ns after the completing edge with the bus idle, so another
  // call can follow immediately as a back-to-back transfer.
  task automatic applyStimulus(input int k, input bit wr, input logic [15:0] a,
                               input logic [31:0] d, input logic [3:0] s,
                               output logic [31:0] rd, output bit er, output int ncyc);
    psel    = 3'b000;
    psel[k] = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = a;
    pwdata  = d;
    pstrb   = s;
    rd      = '0;
    er      = 1'b0;
    ncyc    = 0;
    @(posedge PCLK); #1;
    penable = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge PCLK);
      ncyc++;
      if (pready[k]) begin
        rd = prdata[k];
        er = pslverr[k];
        @(posedge PCLK); #1;
        psel    = 3'b000;
        penable = 1'b0;
        return;
      end
      @(posedge PCLK); #1;
    end
    checks++;
    errors++;
    $display("[TB] FAIL timeout u%0d addr=%h actual=no_pready expected=pready", k, a);
    psel    = 3'b000;
    penable = 1'b0;
  endtask

  task automatic doWrite(input int k, input logic [15:0] a, input logic [31:0] d,
                         input logic [3:0] s, input int expCyc, input bit expErr);
    logic [31:0] rd;
    bit          er;
    int          n;
    applyStimulus(k, 1'b1, a, d, s, rd, er, n);
    checkOutput($sformatf("wr_u%0d_%h_cycles", k, a), n, expCyc);
    checkOutput($sformatf("wr_u%0d_%h_err", k, a), {31'b0, er}, {31'b0, expErr});
  endtask

  task automatic doRead(input int k, input logic [15:0] a, input logic [31:0] expData,
                        input int expCyc, input bit expErr);
    logic [31:0] rd;
    bit          er;
    int          n;
    applyStimulus(k, 1'b0, a, 32'h0, 4'hF, rd, er, n);
    checkOutput($sformatf("rd_u%0d_%h_data", k, a), rd, expData);
    checkOutput($sformatf("rd_u%0d_%h_cycles", k, a), n, expCyc);
    checkOutput($sformatf("rd_u%0d_%h_err", k, a), {31'b0, er}, {31'b0, expErr});
  endtask

  // Setup plus one access cycle of a write. The transfer is then killed,
  // either by dropping PSEL or by pulsing PRESETn low mid-cycle.
  task automatic partialWrite(input int k, input logic [15:0] a, input logic [31:0] d,
                              input bit pulseReset);
    psel    = 3'b000;
    psel[k] = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = a;
    pwdata  = d;
    pstrb   = 4'hF;
    @(posedge PCLK); #1;
    penable = 1'b1;
    @(posedge PCLK); #1;
    if (pulseReset) begin
      #3 PRESETn = 1'b0;
      @(negedge PCLK); #1;
      checkOutput($sformatf("rst_u%0d_pready", k), {31'b0, pready[k]}, 32'h0);
      checkOutput($sformatf("rst_u%0d_prdata", k), prdata[k], 32'h0);
      #1 PRESETn = 1'b1;
      #1;
    end
    psel    = 3'b000;
    penable = 1'b0;
    @(posedge PCLK); #1;
  endtask

  initial begin
    psel    = 3'b000;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
    pstrb   = 4'hF;
    PRESETn = 1'b1;
    #1 PRESETn = 1'b0;
    #22 PRESETn = 1'b1;
    @(posedge PCLK); #1;

    for (int i = 0; i < 8; i++) doRead(0, 16'(i*4), RV, 1, 1'b0);
    doRead(1, 16'h001C, RV, 4, 1'b0);

    doWrite(0, 16'h0004, 32'hDEADBEEF, 4'hF, 1, 1'b0);
    doRead(0, 16'h0004, 32'hDEADBEEF, 1, 1'b0);

    doWrite(1, 16'h0008, 32'h12345678, 4'hF, 4, 1'b0);
    doRead(1, 16'h0008, 32'h12345678, 4, 1'b0);

    doWrite(0, 16'h0020, 32'hCAFEF00D, 4'hF, 1, 1'b1);
    doRead(0, 16'h0006, 32'h0, 1, 1'b1);
    doWrite(1, 16'h0002, 32'h0BADCAFE, 4'hF, 4, 1'b1);
    for (int i = 0; i < 8; i++) doRead(0, 16'(i*4), (i == 1) ? 32'hDEADBEEF : RV, 1, 1'b0);

    partialWrite(1, 16'h0010, 32'h55AA55AA, 1'b0);
    doRead(1, 16'h0010, RV, 4, 1'b0);

    doWrite(2, 16'h0014, 32'h0F0F0F0F, 4'hF, 3, 1'b0);
    partialWrite(2, 16'h000C, 32'h77777777, 1'b1);
    doRead(2, 16'h000C, RV, 3, 1'b0);
    doRead(2, 16'h0014, RV, 3, 1'b0);
    doRead(0, 16'h0004, RV, 1, 1'b0);

`ifdef APB_REG_BANK_PSTRB_EN
    doWrite(0, 16'h0000, 32'h11223344, 4'hF, 1, 1'b0);
    doWrite(0, 16'h0000, 32'hAABBCCDD, 4'b0101, 1, 1'b0);
    doRead(0, 16'h0000, 32'h11BB33DD, 1, 1'b0);
    doWrite(0, 16'h0000, 32'hFFFFFFFF, 4'b0000, 1, 1'b0);
    doRead(0, 16'h0000, 32'h11BB33DD, 1, 1'b0);
`endif

    @(posedge PCLK); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global bound in case something stalls outside the per-transfer limits.
  initial begin
    #500000;
    $display("[TB] FAIL global_timeout actual=running expected=finished");
    $fatal(1, "[TB] global timeout");
  end

endmodule

// File: doc/apb_reg_bank.md
APB_REG_BANK -- requirements
Module: apb_reg_bank

Interface
REQ-001 Parameter DW, default 32, SHALL set data width in bits, a multiple of 8.
REQ-002 Parameter AW, default 16, SHALL set the PADDR width.
REQ-003 Parameter NUM, default 8, SHALL set the register count, range 1..2^(AW-2).
REQ-004 Parameter WAIT_CYCLES, default 0, SHALL set the wait states inserted per transfer, range 0..15.
REQ-005 Parameter RESET_VAL, default 0, SHALL set the DW-bit reset value of every register.
REQ-006 PCLK  input  1  clock; all state changes on rising edge.
REQ-007 PRESETn  input  1  asynchronous, active-low reset.
REQ-008 PSEL  input  1  slave select.
REQ-009 PENABLE  input  1  access phase indicator.
REQ-010 PWRITE  input  1  1 = write, 0 = read.
REQ-011 PADDR  input  AW  byte address.
REQ-012 PWDATA  input  DW  write data.
REQ-013 PSTRB  input  DW/8  byte-lane write strobes; present only under APB_REG_BANK_PSTRB_EN.
REQ-014 PRDATA  output  DW  read data.
REQ-015 PREADY  output  1  transfer completes this cycle.
REQ-016 PSLVERR  output  1  transfer error, valid only with PREADY.

Function
REQ-017 Word index SHALL be PADDR[AW-1:2]; an address is legal iff the index < NUM and PADDR[1:0] == 0.
REQ-018 FSM SHALL have two states: IDLE and ACCESS.
REQ-019 In IDLE, PSEL=1 with PENABLE=0 (setup phase) SHALL load wait counter = WAIT_CYCLES and move to ACCESS on the next edge.
REQ-020 In ACCESS with PSEL=1 and PENABLE=1, the counter SHALL decrement each cycle while nonzero.
REQ-021 PREADY SHALL be 1 iff state == ACCESS and counter == 0; with WAIT_CYCLES=0, PREADY is high in the first access cycle.
REQ-022 On the edge where PSEL, PENABLE and PREADY are all 1, the FSM SHALL return to IDLE; a back-to-back setup in the next cycle SHALL be accepted normally.
REQ-023 In ACCESS, PSEL=0 SHALL abort the transfer: return to IDLE, with no write and no PREADY.
REQ-024 A write SHALL commit PWDATA to register[index] on the completing edge, only if the address is legal.
REQ-025 PRDATA SHALL equal register[index] when PREADY=1, PWRITE=0 and the address is legal; otherwise it SHALL be all zeros.
REQ-026 PSLVERR SHALL be 1 iff PREADY=1 and the address is illegal; an illegal write SHALL leave all registers unchanged.
REQ-027 Address, PWRITE and PWDATA SHALL be sampled in the completing cycle; holding them stable from setup is the master's obligation.
REQ-028 In IDLE, PREADY and PSLVERR SHALL be 0.

Reset
REQ-029 PRESETn low SHALL immediately set all registers to RESET_VAL, set the FSM to IDLE and clear the counter, including during a transfer in progress.
REQ-030 During reset, PREADY=0, PSLVERR=0 and PRDATA=0.
REQ-031 After reset deasserts, the first setup phase on or after the first rising edge SHALL be accepted.

Configuration
REQ-032 With APB_REG_BANK_PSTRB_EN defined, the PSTRB port SHALL exist, and a legal write SHALL update only the bytes whose strobe bit is 1; PSTRB=0 SHALL complete without error and without changing any register.
REQ-033 Without APB_REG_BANK_PSTRB_EN, the PSTRB port SHALL be absent and every legal write SHALL update the full word.

Verification
REQ-034 Reset, then read index 0..NUM-1 -> each returns RESET_VAL, PSLVERR=0.
REQ-035 WAIT_CYCLES=0: write 0xDEADBEEF to addr 0x4, then read addr 0x4 -> PREADY high in the first access cycle, read returns 0xDEADBEEF.
REQ-036 WAIT_CYCLES=3: write to addr 0x8 -> PREADY rises on the 4th access cycle; register updates only on that edge.
REQ-037 NUM=8: write to addr 0x20, then read from addr 0x6 -> PSLVERR=1 with PREADY on both, PRDATA=0, all registers unchanged.
REQ-038 PRESETn pulsed low during the access phase of a write to 0xC with WAIT_CYCLES=2 -> no write occurs, FSM is IDLE, register 3 reads RESET_VAL.
REQ-039 APB_REG_BANK_PSTRB_EN defined: register 0 = 0x11223344, write 0xAABBCCDD with PSTRB=4'b0101 -> reads back 0x11BB33DD.
